// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared widths, FSM states and select decode for the bytebeat input demux.
package mux_pkg;

  localparam int IN_W      = 19;
  localparam int OUT_W     = 8;
  localparam int N_DESIGNS = 3;

  localparam logic [1:0] IDX_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GUARD,
    ST_ACTIVE
  } state_e;

  function automatic logic [N_DESIGNS-1:0] onehot3(input logic [1:0] idx);
    logic [N_DESIGNS-1:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/bbm_guard_timer.sv
// rtl/bbm_guard_timer.sv - loadable down-counter timing the all-off interval between designs.
module bbm_guard_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturates at zero so done stays asserted while no guard is running.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/input_demux_bbm.sv
// rtl/input_demux_bbm.sv - registered 1-to-3 input demux with break-before-make switching.
module input_demux_bbm
  import mux_pkg::*;
#(
  parameter int IN_W  = mux_pkg::IN_W,
  parameter int GUARD = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [1:0]      req_idx,
  output logic            req_ready,
  input  logic [IN_W-1:0] input_bus,
  output logic [IN_W-1:0] input_a,
  output logic [IN_W-1:0] input_b,
  output logic [IN_W-1:0] input_c,
  output logic [2:0]      sel,
  output logic            busy
);

  localparam logic [3:0] GUARD_LOAD = 4'(GUARD - 1);

  state_e          state_q, state_d;
  logic [1:0]      cur_idx_q, cur_idx_d;
  logic [1:0]      tgt_idx_q, tgt_idx_d;
  logic [2:0]      sel_q, sel_d;
  logic [IN_W-1:0] input_a_q, input_a_d;
  logic [IN_W-1:0] input_b_q, input_b_d;
  logic [IN_W-1:0] input_c_q, input_c_d;
  logic            busy_q, busy_d;

  logic accept;
  logic tmr_load;
  logic tmr_done;

  assign req_ready = (state_q != ST_GUARD);
  assign accept    = req_valid && req_ready;

  bbm_guard_timer #(
    .CNT_W(4)
  ) u_guard_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(GUARD_LOAD),
    .done    (tmr_done)
  );

  // sel_d is the select that will be visible next cycle; the data path keys off it so
  // the selected output and sel always switch on the same edge.
  always_comb begin
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    tgt_idx_d = tgt_idx_q;
    sel_d     = sel_q;
    tmr_load  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sel_d = 3'b000;
        if (accept && (req_idx != cur_idx_q)) begin
          state_d   = ST_GUARD;
          tgt_idx_d = req_idx;
          tmr_load  = 1'b1;
        end
      end
      ST_ACTIVE: begin
        sel_d = onehot3(cur_idx_q);
        if (accept && (req_idx != cur_idx_q)) begin
          state_d   = ST_GUARD;
          tgt_idx_d = req_idx;
          tmr_load  = 1'b1;
          sel_d     = 3'b000;
        end
      end
      ST_GUARD: begin
        sel_d = 3'b000;
        if (tmr_done) begin
          if (tgt_idx_q == IDX_NONE) begin
            state_d   = ST_IDLE;
            cur_idx_d = IDX_NONE;
          end else begin
            state_d   = ST_ACTIVE;
            cur_idx_d = tgt_idx_q;
            sel_d     = onehot3(tgt_idx_q);
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cur_idx_d = IDX_NONE;
        sel_d     = 3'b000;
      end
    endcase

    input_a_d = sel_d[0] ? input_bus : '0;
    input_b_d = sel_d[1] ? input_bus : '0;
    input_c_d = sel_d[2] ? input_bus : '0;
    busy_d    = (state_d == ST_GUARD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_idx_q <= IDX_NONE;
      tgt_idx_q <= IDX_NONE;
      sel_q     <= 3'b000;
      input_a_q <= '0;
      input_b_q <= '0;
      input_c_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_idx_q <= cur_idx_d;
      tgt_idx_q <= tgt_idx_d;
      sel_q     <= sel_d;
      input_a_q <= input_a_d;
      input_b_q <= input_b_d;
      input_c_q <= input_c_d;
      busy_q    <= busy_d;
    end
  end

  assign sel     = sel_q;
  assign input_a = input_a_q;
  assign input_b = input_b_q;
  assign input_c = input_c_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_input_demux_bbm.sv
// tb/tb_input_demux_bbm.sv - directed vector table plus corner sequences for input_demux_bbm.
module tb_input_demux_bbm;

  localparam int W     = 19;
  localparam int GUARD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic [1:0]   req_idx = 2'd0;
  logic         req_ready;
  logic [W-1:0] input_bus = '0;
  logic [W-1:0] input_a, input_b, input_c;
  logic [2:0]   sel;
  logic         busy;

  int checks = 0;
  int errors = 0;
  bit inv_on = 1'b0;

  always #5 clk = ~clk;

  input_demux_bbm #(.IN_W(W), .GUARD(GUARD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_idx  (req_idx),
    .req_ready(req_ready),
    .input_bus(input_bus),
    .input_a  (input_a),
    .input_b  (input_b),
    .input_c  (input_c),
    .sel      (sel),
    .busy     (busy)
  );

  typedef struct {
    logic         rst;
    logic         v;
    logic [1:0]   idx;
    logic [W-1:0] bus;
    logic [2:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic         busy;
    logic         rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic v, input logic [1:0] idx,
                              input int bus, input logic [2:0] s, input int a,
                              input int b, input int c, input logic bz, input logic rd);
    vec_t t;
    t.rst = r; t.v = v; t.idx = idx; t.bus = W'(bus);
    t.sel = s; t.a = W'(a); t.b = W'(b); t.c = W'(c); t.busy = bz; t.rdy = rd;
    vecs.push_back(t);
  endfunction

  function automatic void addg(input logic v, input logic [1:0] idx, input int bus);
    add(1'b0, v, idx, bus, 3'b000, 0, 0, 0, 1'b1, 1'b0);
  endfunction

  always @(negedge clk) begin
    if (inv_on) begin
      checks++;
      if (($countones(sel) > 1) ||
          ((input_a != 0) + (input_b != 0) + (input_c != 0) > 1) ||
          (busy && (sel != 3'b000))) begin
        errors++;
        $display("FAIL invariant t=%0t sel=%b a=%0d b=%0d c=%0d busy=%b", $time,
                 sel, input_a, input_b, input_c, busy);
      end
    end
  end

  initial begin
    int n;
    bit hit;

    // reset then idle
    add(1, 0, 0, 42, 3'b000, 0, 0, 0, 0, 1);
    add(1, 0, 0, 42, 3'b000, 0, 0, 0, 0, 1);
    // initial select of a: accepted, 4 guard cycles, then sel=001
    addg(1, 0, 42);
    for (int i = 0; i < 3; i++) addg(0, 0, 42);
    add(0, 0, 0, 42, 3'b001, 42, 0, 0, 0, 1);
    // switch a->c
    addg(1, 2, 43);
    for (int i = 0; i < 3; i++) addg(0, 0, 43);
    add(0, 0, 0, 44, 3'b100, 0, 0, 44, 0, 1);
    add(0, 0, 0, 45, 3'b100, 0, 0, 45, 0, 1);
    // switch c->b, then same-index requests are no-ops
    addg(1, 1, 45);
    for (int i = 0; i < 3; i++) addg(0, 0, 46);
    add(0, 0, 0, 47, 3'b010, 0, 47, 0, 0, 1);
    add(0, 1, 1, 48, 3'b010, 0, 48, 0, 0, 1);
    add(0, 1, 1, 49, 3'b010, 0, 49, 0, 0, 1);
    // request to a, then b held during guard: accepted on first ACTIVE(a) cycle
    addg(1, 0, 50);
    for (int i = 0; i < 3; i++) addg(1, 1, 50);
    add(0, 1, 1, 51, 3'b001, 51, 0, 0, 0, 1);
    addg(1, 1, 52);
    for (int i = 0; i < 3; i++) addg(0, 0, 52);
    add(0, 0, 0, 53, 3'b010, 0, 53, 0, 0, 1);
    // back to a, then deselect to IDLE, then idx 3 in IDLE is a no-op
    addg(1, 0, 53);
    for (int i = 0; i < 3; i++) addg(0, 0, 54);
    add(0, 0, 0, 54, 3'b001, 54, 0, 0, 0, 1);
    addg(1, 3, 54);
    for (int i = 0; i < 3; i++) addg(0, 0, 54);
    add(0, 0, 0, 54, 3'b000, 0, 0, 0, 0, 1);
    add(0, 1, 3, 55, 3'b000, 0, 0, 0, 0, 1);
    // reset on guard cycle 2 with a concurrent request; pending target c discarded
    addg(1, 2, 55);
    addg(0, 0, 55);
    add(1, 1, 0, 55, 3'b000, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 56, 3'b000, 0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      rst       = vecs[i].rst;
      req_valid = vecs[i].v;
      req_idx   = vecs[i].idx;
      input_bus = vecs[i].bus;
      @(posedge clk);
      #1;
      inv_on = 1'b1;
      checks++;
      if (sel !== vecs[i].sel || input_a !== vecs[i].a || input_b !== vecs[i].b ||
          input_c !== vecs[i].c || busy !== vecs[i].busy || req_ready !== vecs[i].rdy) begin
        errors++;
        $display("FAIL vec%0d got sel=%b a=%0d b=%0d c=%0d busy=%b rdy=%b exp sel=%b a=%0d b=%0d c=%0d busy=%b rdy=%b",
                 i, sel, input_a, input_b, input_c, busy, req_ready,
                 vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].busy, vecs[i].rdy);
      end
    end

    // guard length from IDLE: GUARD edges after acceptance until sel=010
    req_valid = 1'b1; req_idx = 2'd1; input_bus = 19'd77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0; hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(posedge clk); #1;
      n++;
      if (sel == 3'b010) hit = 1'b1;
    end
    checks++;
    if (!hit || n != GUARD || input_b !== 19'd77) begin
      errors++;
      $display("FAIL guard_len got hit=%b edges=%0d b=%0d exp edges=%0d b=77", hit, n, input_b, GUARD);
    end

    // rst has priority over a simultaneous request in ACTIVE
    rst = 1'b1; req_valid = 1'b1; req_idx = 2'd2;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    checks++;
    if (sel !== 3'b000 || input_b !== '0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_prio got sel=%b b=%0d busy=%b rdy=%b exp sel=000 b=0 busy=0 rdy=1",
               sel, input_b, busy, req_ready);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (sel !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_discard got sel=%b busy=%b exp sel=000 busy=0", sel, busy);
    end

    inv_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
